// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data-memory responder.
package dmem_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   localparam int DMEM_WORD_BYTES = 4;
   localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_responder_if.sv
// M-stage load/store bus between the datapath (master) and the responder.
// Carries byteen only when DMEM_BYTE_EN is defined.
interface dmem_responder_if;
   logic        memreq;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        stall;
   logic        misalign;
`ifdef DMEM_BYTE_EN
   logic [3:0]  byteen;
`endif

   modport master (
`ifdef DMEM_BYTE_EN
      output byteen,
`endif
      output memreq, memwrite, addr, wdata,
      input  rdata, rvalid, stall, misalign
   );

   modport slave (
`ifdef DMEM_BYTE_EN
      input  byteen,
`endif
      input  memreq, memwrite, addr, wdata,
      output rdata, rvalid, stall, misalign
   );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous masked write, read data registered
// by the responder.
module dmem_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        wmask,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M-stage port: fixed-latency access with stall.
// Optional byte-lane stores enabled by defining DMEM_BYTE_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int DATA_W  = 32
) (
   input  logic clka,
   input  logic rst,
   dmem_responder_if.slave bus
);
   dmem_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W+1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               we_q, we_d;
   logic [3:0]         be_q, be_d;
   logic [DATA_W-1:0]  ram_rd;
   logic               misal;
   logic               access;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

`ifdef DMEM_BYTE_EN
   assign be_d  = (state_q == IDLE && bus.memreq) ? bus.byteen : be_q;
   assign misal = (addr_q[1:0] != 2'b00) && (be_q == 4'b1111);
`else
   assign be_d  = 4'b1111;
   assign misal = (addr_q[1:0] != 2'b00);
`endif

   // The access happens on the edge that leaves WAIT.
   assign access = (state_q == WAIT) && (cnt_q == '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      rdata_d    = rdata_q;
      bus.stall  = 1'b0;
      bus.rvalid = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.stall = bus.memreq;
            if (bus.memreq) begin
               addr_d  = bus.addr[ADDR_W+1:0];
               wdata_d = bus.wdata;
               we_d    = bus.memwrite;
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            bus.stall = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = DONE;
               if (!we_q) rdata_d = misal ? '0 : ram_rd;
            end
         end
         DONE: begin
            bus.rvalid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= 4'b1111;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         be_q    <= be_d;
      end
   end

   dmem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clka),
      .we    (access && we_q && !misal),
      .wmask (be_q),
      .addr  (addr_q[ADDR_W+1:2]),
      .wdata (wdata_q),
      .rdata (ram_rd)
   );

   assign bus.rdata    = rdata_q;
   assign bus.misalign = bus.rvalid && misal;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array model.
module tb_dmem_responder;
   localparam int LAT    = 2;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 2**ADDR_W;

   logic clka = 1'b0;
   logic rst  = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] model_mem [int];
   logic [31:0] rd_exp = 32'h0;
   logic [3:0]  be_drv = 4'hF;

   dmem_responder_if bus ();

   dmem_responder #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LAT),
      .DATA_W  (32)
   ) dut (
      .clka (clka),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 clka = ~clka;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   // Apply a reference-model update for one completed access.
   function automatic logic [31:0] model_access(input bit we,
         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      bit mis;
      mis = (a[1:0] != 2'b00) && (be == 4'hF);
      if (we) begin
         if (!mis) begin
            w = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'h0;
            for (int b = 0; b < 4; b++)
               if (be[b]) w[8*b +: 8] = d[8*b +: 8];
            model_mem[widx(a)] = w;
         end
      end else begin
         rd_exp = mis ? 32'h0 : model_mem[widx(a)];
      end
      return rd_exp;
   endfunction

   task automatic access(input bit we, input logic [31:0] a,
         input logic [31:0] d, output logic [31:0] rd, output bit mis,
         output int nst, output bit ok);
      @(negedge clka);
      bus.memreq   = 1'b1;
      bus.memwrite = we;
      bus.addr     = a;
      bus.wdata    = d;
`ifdef DMEM_BYTE_EN
      bus.byteen   = be_drv;
`endif
      nst = 0;
      ok  = 1'b0;
      rd  = 32'h0;
      mis = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (bus.rvalid) begin
            rd  = bus.rdata;
            mis = bus.misalign;
            ok  = 1'b1;
            if (bus.stall) nst += 100;
            break;
         end
         if (bus.stall) nst++;
         @(negedge clka);
         bus.memreq   = 1'b0;
         bus.memwrite = 1'b0;
      end
      bus.memreq = 1'b0;
   endtask

   task automatic checked(input string nm, input bit we,
         input logic [31:0] a, input logic [31:0] d, input bit exp_mis);
      logic [31:0] rd, exp;
      bit mis, ok;
      int nst;
      access(we, a, d, rd, mis, nst, ok);
      exp = model_access(we, a, d, be_drv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s timeout: no rvalid within 40 cycles", nm);
         return;
      end
      checks++;
      if (nst !== LAT + 1) begin
         errors++;
         $display("FAIL %s stall_cycles: got %0d want %0d", nm, nst, LAT + 1);
      end
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL %s rdata: got %h want %h", nm, rd, exp);
      end
      checks++;
      if (mis !== exp_mis) begin
         errors++;
         $display("FAIL %s misalign: got %b want %b", nm, mis, exp_mis);
      end
   endtask

   task automatic test_reset();
      bus.memreq   = 1'b0;
      bus.memwrite = 1'b0;
      bus.addr     = '0;
      bus.wdata    = '0;
`ifdef DMEM_BYTE_EN
      bus.byteen   = 4'hF;
`endif
      rst = 1'b0;
      repeat (3) @(negedge clka);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (bus.stall !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: stall=%b rvalid=%b rdata=%h want 0 0 0",
                     bus.stall, bus.rvalid, bus.rdata);
         end
         @(negedge clka);
      end
   endtask

   task automatic test_store_load();
      checked("store_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      #6;
      checks++;
      if (bus.rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rvalid_pulse: got %b want 0", bus.rvalid);
      end
      checked("load_10", 1'b0, 32'h10, 32'h0, 1'b0);
   endtask

   task automatic test_misalign();
      checked("mis_store", 1'b1, 32'h12, 32'h1234_5678, 1'b1);
      checked("load_after_mis", 1'b0, 32'h10, 32'h0, 1'b0);
      checked("mis_load", 1'b0, 32'h11, 32'h0, 1'b1);
   endtask

   task automatic test_wrap();
      checked("wrap_store", 1'b1, 32'h1004, 32'hA5A5_A5A5, 1'b0);
      checked("wrap_load", 1'b0, 32'h0004, 32'h0, 1'b0);
   endtask

   task automatic test_reset_mid();
      checked("old_20", 1'b1, 32'h20, 32'h0BAD_F00D, 1'b0);
      @(negedge clka);
      bus.memreq   = 1'b1;
      bus.memwrite = 1'b1;
      bus.addr     = 32'h20;
      bus.wdata    = 32'hFFFF_FFFF;
      @(negedge clka);
      bus.memreq   = 1'b0;
      bus.memwrite = 1'b0;
      #1;
      checks++;
      if (bus.stall !== 1'b1) begin
         errors++;
         $display("FAIL mid_wait_stall: got %b want 1", bus.stall);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.stall !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset: stall=%b rvalid=%b rdata=%h want 0 0 0",
                  bus.stall, bus.rvalid, bus.rdata);
      end
      rd_exp = 32'h0;
      repeat (2) @(negedge clka);
      rst = 1'b1;
      repeat (3) @(negedge clka);
      checked("load_20_old", 1'b0, 32'h20, 32'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      checked("b2b_full", 1'b1, 32'h30, 32'h1122_3344, 1'b0);
`ifdef DMEM_BYTE_EN
      be_drv = 4'b0101;
      checked("b2b_lanes", 1'b1, 32'h30, 32'hAABB_CCDD, 1'b0);
      be_drv = 4'hF;
      checked("b2b_load", 1'b0, 32'h30, 32'h0, 1'b0);
      checks++;
      if (rd_exp !== 32'h11BB_33DD) begin
         errors++;
         $display("FAIL b2b_lane_model: got %h want 11bb33dd", rd_exp);
      end
`else
      checked("b2b_second", 1'b1, 32'h30, 32'hAABB_CCDD, 1'b0);
      checked("b2b_load", 1'b0, 32'h30, 32'h0, 1'b0);
`endif
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] pool [8];
      logic [31:0] a, d;
      bit we;
      for (int i = 0; i < 8; i++) begin
         pool[i] = ADDR_W'($urandom_range(64, DEPTH - 1));
         checked("rnd_init", 1'b1, {20'h0, pool[i], 2'b00}, $urandom, 1'b0);
      end
      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom_range(0, 1));
         a  = {$urandom_range(0, 1023) * 32'h0, 20'h0, pool[$urandom_range(0, 7)], 2'b00};
         a[31:ADDR_W+2] = $urandom;
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         d = $urandom;
         checked("rnd", we, a, d, a[1:0] != 2'b00);
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_misalign();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clka);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
